pl_stage_fifo: RTL and testbench

Parametrised elastic pipeline stage register for the RV32 core. It replaces fixed single-entry stage latches (EX/MEM style) with a DEPTH-entry buffer that uses valid/ready handshaking, so a stalled downstream stage (e.g. the memory stage waiting on a data-memory wait state) does not force an immediate upstream stall. Each entry carries a control field, which is zeroed to form a bubble, and a data field; a synchronous flush empties the stage for branch/exception recovery.

---
 rtl/pl_stage_fifo.sv | 86 ++++++++
 tb/tb_pl_stage_fifo.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pl_stage_fifo.sv
// rtl/pl_stage_fifo.sv - elastic DEPTH-entry pipeline stage register with valid/ready handshake
// Optional feature macro: PL_STAGE_FIFO_BUBBLE_ZERO_EN (zero out_ctrl/out_data while out_valid=0)
module pl_stage_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 8,
  parameter int DEPTH      = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_flush,
  input  logic                         i_hold,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic [CTRL_WIDTH-1:0]        i_in_ctrl,
  input  logic [DATA_WIDTH-1:0]        i_in_data,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [CTRL_WIDTH-1:0]        o_out_ctrl,
  output logic [DATA_WIDTH-1:0]        o_out_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [CTRL_WIDTH-1:0] r_ctrl [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;

  logic                  w_push;
  logic                  w_pop;
  logic [CTRL_WIDTH-1:0] w_head_ctrl;
  logic [DATA_WIDTH-1:0] w_head_data;

  // Handshake flags come only from registered count, so out_ready never reaches in_ready.
  assign o_in_ready  = (r_count != FULL_CNT);
  assign o_out_valid = (r_count != '0);
  assign w_push      = i_in_valid & o_in_ready;
  assign w_pop       = o_out_valid & i_out_ready & ~i_hold;
  assign w_head_ctrl = r_ctrl[r_rptr];
  assign w_head_data = r_data[r_rptr];
  assign o_count     = r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ctrl[i] <= '0;
        r_data[i] <= '0;
      end
    end else if (i_flush) begin
      // Storage is left as-is; only the bookkeeping is discarded.
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_ctrl[r_wptr] <= i_in_ctrl;
        r_data[r_wptr] <= i_in_data;
        r_wptr         <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef PL_STAGE_FIFO_BUBBLE_ZERO_EN
  assign o_out_ctrl = o_out_valid ? w_head_ctrl : '0;
  assign o_out_data = o_out_valid ? w_head_data : '0;
`else
  assign o_out_ctrl = w_head_ctrl;
  assign o_out_data = w_head_data;
`endif

endmodule

// File: tb/tb_pl_stage_fifo.sv
// tb/tb_pl_stage_fifo.sv - scoreboard bench for pl_stage_fifo (DEPTH=2)
// Honours PL_STAGE_FIFO_BUBBLE_ZERO_EN when choosing expected bubble contents.
module tb_pl_stage_fifo;

  localparam int DW    = 32;
  localparam int CW    = 8;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst, flush, hold, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    count;

  int nchecks = 0;
  int nerr    = 0;

  logic [DW-1:0] q_data [$];
  logic [CW-1:0] q_ctrl [$];
  logic [DW-1:0] m_data [DEPTH];
  logic [CW-1:0] m_ctrl [DEPTH];
  int            m_wptr, m_rptr, m_count;
  bit            chk_en;

  always #5 clk = ~clk;

  pl_stage_fifo #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .DEPTH(DEPTH)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_flush     (flush),
    .i_hold      (hold),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_ctrl   (in_ctrl),
    .i_in_data   (in_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_ctrl  (out_ctrl),
    .o_out_data  (out_data),
    .o_count     (count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic v, input logic [DW-1:0] d);
    in_valid = v;
    in_data  = d;
    in_ctrl  = d[CW-1:0] ^ 8'h5A;
  endtask

  // One clock: check DUT against the model, advance the model, then step the clock.
  task automatic cyc();
    bit            e_push, e_pop;
    logic [DW-1:0] e_data;
    logic [CW-1:0] e_ctrl;
    e_push = in_valid && (m_count != DEPTH);
    e_pop  = (m_count != 0) && out_ready && !hold;
    if (chk_en) begin
      chk("in_ready",  {63'd0, in_ready},  {63'd0, m_count != DEPTH});
      chk("out_valid", {63'd0, out_valid}, {63'd0, m_count != 0});
      chk("count",     {62'd0, count},     64'(m_count));
      if (m_count != 0) begin
        e_data = q_data[0];
        e_ctrl = q_ctrl[0];
      end else begin
`ifdef PL_STAGE_FIFO_BUBBLE_ZERO_EN
        e_data = '0;
        e_ctrl = '0;
`else
        e_data = m_data[m_rptr];
        e_ctrl = m_ctrl[m_rptr];
`endif
      end
      chk("out_data", 64'(out_data), 64'(e_data));
      chk("out_ctrl", 64'(out_ctrl), 64'(e_ctrl));
    end
    if (rst) begin
      m_wptr = 0; m_rptr = 0; m_count = 0;
      for (int i = 0; i < DEPTH; i++) begin
        m_data[i] = '0;
        m_ctrl[i] = '0;
      end
      q_data.delete();
      q_ctrl.delete();
    end else if (flush) begin
      m_wptr = 0; m_rptr = 0; m_count = 0;
      q_data.delete();
      q_ctrl.delete();
    end else begin
      if (e_push) begin
        m_data[m_wptr] = in_data;
        m_ctrl[m_wptr] = in_ctrl;
        m_wptr = (m_wptr + 1) % DEPTH;
        q_data.push_back(in_data);
        q_ctrl.push_back(in_ctrl);
      end
      if (e_pop) begin
        m_rptr = (m_rptr + 1) % DEPTH;
        void'(q_data.pop_front());
        void'(q_ctrl.pop_front());
      end
      m_count = m_count + (e_push ? 1 : 0) - (e_pop ? 1 : 0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; hold = 1'b0; out_ready = 1'b1;
    chk_en = 1'b0;
    m_wptr = 0; m_rptr = 0; m_count = 0;
    offer(1'b1, 32'hDEAD_BEEF);
    cyc();
    cyc();
    chk_en = 1'b1;
    rst = 1'b0;
    offer(1'b0, 32'h0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    cyc();
    cyc();

    // Streaming at one entry per cycle.
    offer(1'b1, 32'h11); cyc();
    offer(1'b1, 32'h22); cyc();
    offer(1'b1, 32'h33); cyc();
    offer(1'b0, 32'h0);  cyc();
    cyc();

    // Back-pressure until full, then drain with the third entry re-offered.
    out_ready = 1'b0;
    offer(1'b1, 32'hA0); cyc();
    offer(1'b1, 32'hA1); cyc();
    offer(1'b1, 32'hA2); cyc();
    cyc();
    out_ready = 1'b1;
    cyc();
    cyc();
    offer(1'b0, 32'h0); cyc();
    cyc();

    // Hold blocks pops, then simultaneous push/pop with pointer wrap.
    out_ready = 1'b0;
    offer(1'b1, 32'hB0); cyc();
    out_ready = 1'b1; hold = 1'b1;
    offer(1'b1, 32'hB1); cyc();
    hold = 1'b0;
    offer(1'b1, 32'hB2); cyc();
    offer(1'b1, 32'hB3); cyc();
    offer(1'b1, 32'hB4); cyc();
    offer(1'b0, 32'h0);  cyc();
    cyc();
    cyc();

    // Flush while full with a push in the same cycle.
    out_ready = 1'b0;
    offer(1'b1, 32'hC0); cyc();
    offer(1'b1, 32'hC1); cyc();
    flush = 1'b1;
    offer(1'b1, 32'hD0); cyc();
    flush = 1'b0;
    offer(1'b0, 32'h0);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    cyc();
    out_ready = 1'b1;
    offer(1'b1, 32'hE0); cyc();
    offer(1'b1, 32'hE1); cyc();
    offer(1'b0, 32'h0);  cyc();
    cyc();

    // Reset asserted mid-stream.
    out_ready = 1'b0;
    offer(1'b1, 32'hF0); cyc();
    offer(1'b1, 32'hF1); cyc();
    rst = 1'b1; cyc();
    rst = 1'b0;
    offer(1'b0, 32'h0);
    chk("rst2_out_data", 64'(out_data), 64'd0);
    cyc();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
